// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default-value helper for the shadow register file
package regfile_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } commit_state_t;

   localparam int DEF_MAX_W = 8192;
   localparam int REG_MAX_W = 64;

   // Caller zero-extends the flat defaults to DEF_MAX_W and truncates the result to its register width.
   function automatic logic [REG_MAX_W-1:0] reg_default(input logic [DEF_MAX_W-1:0] flat,
                                                        input int idx,
                                                        input int data_w);
      return REG_MAX_W'(flat >> (idx * data_w));
   endfunction

endpackage

// File: rtl/regfile_commit_ctrl.sv
// rtl/regfile_commit_ctrl.sv - commit FSM: holds a shadow->active request until apply_ok
module regfile_commit_ctrl
   import regfile_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic commit_req,
   input  logic apply_ok,
   output logic apply,
   output logic commit_pending,
   output logic commit_done
);

   commit_state_t state, state_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         commit_done <= 1'b0;
      end else begin
         state       <= state_next;
         commit_done <= apply;
      end
   end

   // Requests arriving while already pending are absorbed, never queued.
   always_comb begin
      state_next = state;
      apply      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (commit_req) begin
               if (apply_ok) apply = 1'b1;
               else          state_next = ST_PEND;
            end
         end
         ST_PEND: begin
            if (apply_ok) begin
               apply      = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign commit_pending = (state == ST_PEND);

endmodule

// File: rtl/regfile_shadow.sv
// rtl/regfile_shadow.sv - double-buffered config register file with lock, error flags and readback
module regfile_shadow
   import regfile_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int NUMREGS   = 67,
   parameter int ADDR_W    = 8,
   parameter int LOCK_ADDR = NUMREGS - 1,
   parameter logic [NUMREGS*DATA_W-1:0] DEFAULTS = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              write,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic              read,
   input  logic [ADDR_W-1:0] read_addr,
   input  logic              read_sel,
   output logic [DATA_W-1:0] read_data,
   output logic              read_valid,
   input  logic              commit_req,
   input  logic              apply_ok,
   output logic              commit_pending,
   output logic              commit_done,
   output logic              dirty,
   output logic              err_addr,
   output logic              err_lock,
   input  logic              err_clr,
   output logic [DATA_W-1:0] config_bits [0:NUMREGS-1]
);

   localparam logic [DEF_MAX_W-1:0] DEF_EXT = DEF_MAX_W'(DEFAULTS);
   localparam logic [ADDR_W:0]      NUM_EXT = (ADDR_W + 1)'(NUMREGS);
   localparam logic [ADDR_W-1:0]    LOCK_A  = ADDR_W'(LOCK_ADDR);

   logic [DATA_W-1:0] shadow [0:NUMREGS-1];
   logic [DATA_W-1:0] active [0:NUMREGS-1];
   logic              apply;
   logic              lock;
   logic              w_in_range;
   logic              r_in_range;
   logic              write_ok;
   logic              lock_hit;
   logic              addr_hit;
   logic [DATA_W-1:0] rd_mux;

   regfile_commit_ctrl u_commit (
      .clk            (clk),
      .reset_n        (reset_n),
      .commit_req     (commit_req),
      .apply_ok       (apply_ok),
      .apply          (apply),
      .commit_pending (commit_pending),
      .commit_done    (commit_done)
   );

   assign lock       = shadow[LOCK_ADDR][0];
   assign w_in_range = ({1'b0, write_addr} < NUM_EXT);
   assign r_in_range = ({1'b0, read_addr} < NUM_EXT);
   // The lock register itself stays writable so a locked bank can be unlocked.
   assign write_ok   = write && w_in_range && (!lock || write_addr == LOCK_A);
   assign lock_hit   = write && w_in_range && lock && (write_addr != LOCK_A);
   assign addr_hit   = (write && !w_in_range) || (read && !r_in_range);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUMREGS; i++)
            shadow[i] <= DATA_W'(reg_default(DEF_EXT, i, DATA_W));
      end else begin
         for (int i = 0; i < NUMREGS; i++)
            if (write_ok && write_addr == ADDR_W'(i)) shadow[i] <= write_data;
      end
   end

   // Nonblocking copy: a write landing on the apply edge is not seen by active.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUMREGS; i++)
            active[i] <= DATA_W'(reg_default(DEF_EXT, i, DATA_W));
      end else if (apply) begin
         active <= shadow;
      end
   end

   assign config_bits = active;

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUMREGS; i++)
         if (read_addr == ADDR_W'(i)) rd_mux = read_sel ? active[i] : shadow[i];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         read_data  <= '0;
         read_valid <= 1'b0;
         dirty      <= 1'b0;
         err_addr   <= 1'b0;
         err_lock   <= 1'b0;
      end else begin
         read_valid <= read;
         if (read) read_data <= rd_mux;

         if (write_ok)   dirty <= 1'b1;
         else if (apply) dirty <= 1'b0;

         if (addr_hit)     err_addr <= 1'b1;
         else if (err_clr) err_addr <= 1'b0;

         if (lock_hit)     err_lock <= 1'b1;
         else if (err_clr) err_lock <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_shadow.sv
// tb/tb_regfile_shadow.sv - scoreboard bench for regfile_shadow
module tb_regfile_shadow;

   localparam int DW = 8;
   localparam int NR = 67;
   localparam int AW = 8;
   localparam logic [NR*DW-1:0] DEFS = ((NR*DW)'(8'h3C) << 40) | ((NR*DW)'(8'h5A) << 56);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          write = 1'b0;
   logic [AW-1:0] write_addr = '0;
   logic [DW-1:0] write_data = '0;
   logic          read = 1'b0;
   logic [AW-1:0] read_addr = '0;
   logic          read_sel = 1'b0;
   logic [DW-1:0] read_data;
   logic          read_valid;
   logic          commit_req = 1'b0;
   logic          apply_ok = 1'b0;
   logic          commit_pending;
   logic          commit_done;
   logic          dirty;
   logic          err_addr;
   logic          err_lock;
   logic          err_clr = 1'b0;
   logic [DW-1:0] config_bits [0:NR-1];

   int            checks = 0;
   int            errors = 0;
   int            done_cnt = 0;
   int            done_base;
   logic [DW-1:0] exp_q [$];

   regfile_shadow #(
      .DATA_W   (DW),
      .NUMREGS  (NR),
      .ADDR_W   (AW),
      .LOCK_ADDR(NR - 1),
      .DEFAULTS (DEFS)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .write          (write),
      .write_addr     (write_addr),
      .write_data     (write_data),
      .read           (read),
      .read_addr      (read_addr),
      .read_sel       (read_sel),
      .read_data      (read_data),
      .read_valid     (read_valid),
      .commit_req     (commit_req),
      .apply_ok       (apply_ok),
      .commit_pending (commit_pending),
      .commit_done    (commit_done),
      .dirty          (dirty),
      .err_addr       (err_addr),
      .err_lock       (err_lock),
      .err_clr        (err_clr),
      .config_bits    (config_bits)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      write = 1'b1; write_addr = a; write_data = d;
      tick();
      write = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic sel, input logic [DW-1:0] exp);
      read = 1'b1; read_addr = a; read_sel = sel;
      exp_q.push_back(exp);
      tick();
      read = 1'b0;
   endtask

   // Read monitor: every read_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (read_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_read_valid", 32'(read_valid), 32'd0);
         end else begin
            check("read_data", 32'(read_data), 32'(exp_q.pop_front()));
         end
      end
      if (commit_done) done_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      check("rst_cfg5", 32'(config_bits[5]), 32'h3C);
      check("rst_cfg7", 32'(config_bits[7]), 32'h5A);
      check("rst_read_valid", 32'(read_valid), 0);
      check("rst_read_data", 32'(read_data), 0);
      check("rst_pending", 32'(commit_pending), 0);
      check("rst_done", 32'(commit_done), 0);
      check("rst_dirty", 32'(dirty), 0);
      check("rst_errs", {30'd0, err_addr, err_lock}, 0);
      reset_n = 1'b1;
      tick();

      // 1: default readback from active bank
      do_read(8'd5, 1'b1, 8'h3C);
      check("rv_pulse_len", 32'(read_valid), 1);
      tick();
      check("rv_pulse_drop", 32'(read_valid), 0);
      check("rd_hold", 32'(read_data), 32'h3C);

      // 2: write shadow, then immediate commit
      do_write(8'd5, 8'hA5);
      check("dirty_set", 32'(dirty), 1);
      do_read(8'd5, 1'b0, 8'hA5);
      do_read(8'd5, 1'b1, 8'h3C);
      commit_req = 1'b1; apply_ok = 1'b1;
      tick();
      commit_req = 1'b0; apply_ok = 1'b0;
      check("cfg5_applied", 32'(config_bits[5]), 32'hA5);
      check("done_pulse", 32'(commit_done), 1);
      check("dirty_clr", 32'(dirty), 0);
      tick();
      check("done_drop", 32'(commit_done), 0);

      // 3: deferred commit, absorbed duplicate request
      do_write(8'd6, 8'h42);
      done_base = done_cnt;
      commit_req = 1'b1;
      repeat (10) tick();
      check("pending", 32'(commit_pending), 1);
      check("cfg6_held", 32'(config_bits[6]), 0);
      commit_req = 1'b0; apply_ok = 1'b1;
      tick();
      apply_ok = 1'b0;
      check("cfg6_applied", 32'(config_bits[6]), 32'h42);
      check("pending_clr", 32'(commit_pending), 0);
      tick();
      check("one_done", done_cnt - done_base, 1);
      done_base = done_cnt;
      commit_req = 1'b1;
      repeat (4) tick();
      commit_req = 1'b0;
      tick();
      apply_ok = 1'b1;
      tick();
      apply_ok = 1'b0;
      repeat (3) tick();
      check("absorbed_done", done_cnt - done_base, 1);

      // 4: lock register
      do_write(8'd66, 8'h01);
      do_write(8'd3, 8'h77);
      check("err_lock_set", 32'(err_lock), 1);
      check("lock_no_addr_err", 32'(err_addr), 0);
      do_read(8'd3, 1'b0, 8'h00);
      do_write(8'd66, 8'h00);
      do_write(8'd3, 8'h77);
      do_read(8'd3, 1'b0, 8'h77);
      check("err_lock_sticky", 32'(err_lock), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("err_lock_clr", 32'(err_lock), 0);

      // 5: out-of-range write and read in the same cycle
      write = 1'b1; write_addr = 8'd200; write_data = 8'hFF;
      read = 1'b1; read_addr = 8'd100; read_sel = 1'b0;
      exp_q.push_back(8'h00);
      tick();
      write = 1'b0; read = 1'b0;
      check("err_addr_set", 32'(err_addr), 1);
      check("oor_no_lock", 32'(err_lock), 0);
      write = 1'b1; write_addr = 8'd67; err_clr = 1'b1;
      tick();
      write = 1'b0; err_clr = 1'b0;
      check("err_set_wins", 32'(err_addr), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("err_addr_clr", 32'(err_addr), 0);
      do_read(8'd66, 1'b0, 8'h00);

      // 6: write coinciding with apply
      write = 1'b1; write_addr = 8'd7; write_data = 8'h11;
      commit_req = 1'b1; apply_ok = 1'b1;
      tick();
      write = 1'b0; commit_req = 1'b0; apply_ok = 1'b0;
      check("cfg7_old", 32'(config_bits[7]), 32'h5A);
      check("cfg3_applied", 32'(config_bits[3]), 32'h77);
      check("dirty_kept", 32'(dirty), 1);
      do_read(8'd7, 1'b0, 8'h11);
      do_read(8'd7, 1'b1, 8'h5A);
      write = 1'b1; write_addr = 8'd8; write_data = 8'h99;
      read = 1'b1; read_addr = 8'd8; read_sel = 1'b0;
      exp_q.push_back(8'h00);
      tick();
      write = 1'b0; read = 1'b0;
      do_read(8'd8, 1'b0, 8'h99);

      // reset while pending
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      check("pend_before_rst", 32'(commit_pending), 1);
      tick();
      reset_n = 1'b0;
      #1;
      check("rst2_pending", 32'(commit_pending), 0);
      check("rst2_dirty", 32'(dirty), 0);
      check("rst2_cfg5", 32'(config_bits[5]), 32'h3C);
      check("rst2_cfg3", 32'(config_bits[3]), 0);
      check("rst2_read_data", 32'(read_data), 0);
      tick();
      reset_n = 1'b1;
      tick();
      done_base = done_cnt;
      apply_ok = 1'b1;
      repeat (2) tick();
      apply_ok = 1'b0;
      tick();
      check("no_commit_after_rst", done_cnt - done_base, 0);
      do_read(8'd5, 1'b0, 8'h3C);
      do_read(8'd7, 1'b0, 8'h5A);
      repeat (2) tick();
      check("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
